// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared parameters, state encoding and saturating add for the pixel histogram
package hist_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int CNT_W_DEF = 20;
  localparam int NUM_BINS  = 2**PIX_W_DEF;

  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, READOUT} hist_state_t;

  // Widths up to 32 bits; callers cast operands in and the result back out.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_val}) ? max_val : s[31:0];
  endfunction

endpackage

// File: rtl/pixel_histogram_if.sv
// rtl/pixel_histogram_if.sv - pixel input stream and histogram output stream of the pixel histogram
interface pixel_histogram_if #(
  parameter int PIX_W = hist_pkg::PIX_W_DEF,
  parameter int CNT_W = hist_pkg::CNT_W_DEF
);
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_eof;
  logic             pix_ready;
  logic             hist_valid;
  logic             hist_ready;
  logic [PIX_W-1:0] hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic             done;

  modport master (output pix_valid, pix_data, pix_eof, hist_ready,
                  input  pix_ready, hist_valid, hist_bin, hist_count, done);
  modport slave  (input  pix_valid, pix_data, pix_eof, hist_ready,
                  output pix_ready, hist_valid, hist_bin, hist_count, done);
endinterface

// File: rtl/hist_ram.sv
// rtl/hist_ram.sv - simple dual-port bin RAM, one write port, one enabled 1-cycle read port
module hist_ram
  import hist_pkg::*;
#(
  parameter int AW = PIX_W_DEF,
  parameter int DW = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // A same-address read returns the value from before this cycle's write.
  always_ff @(posedge clk) begin
    if (we)    mem[waddr] <= wdata;
    if (rd_en) rdata      <= mem[raddr];
  end
endmodule

// File: rtl/pixel_histogram.sv
// rtl/pixel_histogram.sv - per-frame pixel histogram with clear-on-read readout
// HIST_CDF_EN defined: beat k carries the saturated running sum of bins 0..k.
module pixel_histogram
  import hist_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pixel_histogram_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PIX_W-1:0] LAST_BIN = '1;

  hist_state_t      state;
  logic [PIX_W-1:0] clr_addr;
  logic             pix_ready_q, hist_valid_q, done_q;
  logic [PIX_W-1:0] hist_bin_q;
  logic [CNT_W-1:0] hist_count_q;
  logic             s1_valid, fwd_valid;
  logic [PIX_W-1:0] s1_bin, fwd_bin;
  logic [CNT_W-1:0] fwd_val;
  logic [PIX_W:0]   issue_bin;
  logic [PIX_W-1:0] rd_bin;
  logic             rd_pend;

  logic             accept, hs, out_ld, issue, rd_en, we;
  logic [PIX_W-1:0] rd_addr, waddr;
  logic [CNT_W-1:0] rd_data, wdata, cur, inc, beat_val;

  assign accept  = bus.pix_valid && pix_ready_q;
  assign hs      = hist_valid_q && bus.hist_ready;
  assign out_ld  = (state == READOUT) && rd_pend && (!hist_valid_q || bus.hist_ready);
  assign issue   = (state == READOUT) && !issue_bin[PIX_W] && (!rd_pend || out_ld);
  assign rd_en   = accept || issue;
  assign rd_addr = (state == READOUT) ? issue_bin[PIX_W-1:0] : bus.pix_data;

  // The previous cycle's write to the same bin is not yet visible in rd_data.
  assign cur = (fwd_valid && fwd_bin == s1_bin) ? fwd_val : rd_data;
  assign inc = CNT_W'(sat_add(32'(cur), 32'd1, 32'(CNT_MAX)));

`ifdef HIST_CDF_EN
  logic [CNT_W-1:0] cdf_acc;
  assign beat_val = CNT_W'(sat_add(32'(cdf_acc), 32'(rd_data), 32'(CNT_MAX)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cdf_acc <= '0;
    else if (state == DRAIN)   cdf_acc <= '0;
    else if (out_ld)           cdf_acc <= beat_val;
  end
`else
  assign beat_val = rd_data;
`endif

  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = '0;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (s1_valid) begin
      we    = 1'b1;
      waddr = s1_bin;
      wdata = inc;
    end else if (hs) begin
      we    = 1'b1;
      waddr = hist_bin_q;
    end
  end

  hist_ram #(.AW(PIX_W), .DW(CNT_W)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .raddr(rd_addr), .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR;
      clr_addr     <= '0;
      pix_ready_q  <= 1'b0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= '0;
      hist_count_q <= '0;
      done_q       <= 1'b0;
      s1_valid     <= 1'b0;
      s1_bin       <= '0;
      fwd_valid    <= 1'b0;
      fwd_bin      <= '0;
      fwd_val      <= '0;
      issue_bin    <= '0;
      rd_bin       <= '0;
      rd_pend      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      s1_valid  <= accept;
      s1_bin    <= bus.pix_data;
      fwd_valid <= s1_valid;
      fwd_bin   <= s1_bin;
      fwd_val   <= inc;
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_BIN) begin
            state       <= ACCUM;
            pix_ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept && bus.pix_eof) begin
            state       <= DRAIN;
            pix_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          state     <= READOUT;
          issue_bin <= '0;
          rd_pend   <= 1'b0;
        end
        READOUT: begin
          // rd_data holds while rd_pend, acting as the prefetch slot behind the output register.
          if (issue) begin
            issue_bin <= issue_bin + 1'b1;
            rd_bin    <= issue_bin[PIX_W-1:0];
            rd_pend   <= 1'b1;
          end else if (out_ld) begin
            rd_pend <= 1'b0;
          end
          if (out_ld) begin
            hist_valid_q <= 1'b1;
            hist_bin_q   <= rd_bin;
            hist_count_q <= beat_val;
          end else if (hs) begin
            hist_valid_q <= 1'b0;
          end
          if (hs && hist_bin_q == LAST_BIN) begin
            state        <= ACCUM;
            pix_ready_q  <= 1'b1;
            done_q       <= 1'b1;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= '0;
            hist_count_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.hist_valid = hist_valid_q;
  assign bus.hist_bin   = hist_bin_q;
  assign bus.hist_count = hist_count_q;
  assign bus.done       = done_q;
endmodule
